// File: rtl/bcd_display_mux.sv
// Time-multiplexed driver for a 4-digit common-anode seven-segment display.
// The BCD inputs are captured once per frame so that a display frame never mixes old and new digits.
module bcd_display_mux #(
  parameter int REFRESH_DIV = 100000,
  parameter bit BLANK_LZ    = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] BCD3,
  input  logic [3:0] BCD2,
  input  logic [3:0] BCD1,
  input  logic [3:0] BCD0,
  input  logic [3:0] dp_en,
  output logic [6:0] seg,
  output logic       dp,
  output logic [3:0] an
);

  localparam int PW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(REFRESH_DIV - 1);

  logic [PW-1:0]   presc;
  logic [1:0]      idx;
  logic            tick;
  logic [3:0][3:0] snap_bcd;
  logic [3:0]      snap_dp;
  logic [3:0]      blank;
  logic            live;
  logic [3:0]      an_p0;
  logic [6:0]      seg_p0;
  logic            dp_p0;

  // Active-low {g,f,e,d,c,b,a}; non-decimal codes show a lone dash on g.
  function automatic logic [6:0] seg_decode(input logic [3:0] v);
    case (v)
      4'd0:    seg_decode = 7'b1000000;
      4'd1:    seg_decode = 7'b1111001;
      4'd2:    seg_decode = 7'b0100100;
      4'd3:    seg_decode = 7'b0110000;
      4'd4:    seg_decode = 7'b0011001;
      4'd5:    seg_decode = 7'b0010010;
      4'd6:    seg_decode = 7'b0000010;
      4'd7:    seg_decode = 7'b1111000;
      4'd8:    seg_decode = 7'b0000000;
      4'd9:    seg_decode = 7'b0010000;
      default: seg_decode = 7'b0111111;
    endcase
  endfunction

  assign tick = (presc == PMAX);

  // A digit stays lit once any digit or decimal point at or above it is non-zero.
  always_comb begin
    blank = 4'b0000;
    live  = 1'b0;
    for (int k = 3; k >= 1; k--) begin
      live     = live | (snap_bcd[k] != 4'd0) | snap_dp[k];
      blank[k] = BLANK_LZ & ~live;
    end
  end

  always_comb begin
    an_p0  = 4'b1111;
    seg_p0 = seg_decode(snap_bcd[idx]);
    dp_p0  = 1'b1;
    if (!blank[idx]) begin
      an_p0 = ~(4'b0001 << idx);
      dp_p0 = ~snap_dp[idx];
    end
  end

  // Stage p0 -> registered display outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      presc    <= '0;
      idx      <= 2'd0;
      snap_bcd <= '0;
      snap_dp  <= 4'b0000;
      an       <= 4'b1111;
      seg      <= 7'b1111111;
      dp       <= 1'b1;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) begin
        idx <= idx + 2'd1;
        if (idx == 2'd3) begin
          snap_bcd <= {BCD3, BCD2, BCD1, BCD0};
          snap_dp  <= dp_en;
        end
      end
      an  <= an_p0;
      seg <= seg_p0;
      dp  <= dp_p0;
    end
  end

endmodule

// File: doc/bcd_display_mux.md
Name: bcd_display_mux

Overview:
- Downstream consumer of the 4-digit BCD counter outputs BCD3..BCD0.
- Drives a 4-digit common-anode seven-segment display by time-multiplexing one digit at a time.
- Uses a refresh prescaler, a digit-scan counter and a per-frame snapshot of the BCD inputs, so a counter update mid-scan never produces a torn frame.
- Provides BCD-to-segment decode, invalid-code indication, decimal points and optional leading-zero blanking.

Parameters:
- REFRESH_DIV, 100000: clk cycles per digit slot. Legal range is 2 or more; 100 MHz gives 1 kHz per digit.
- BLANK_LZ, 1: 1 enables leading-zero blanking; 0 shows all four digits always.

Ports:
- clk  input  1  system clock; all logic is on its rising edge.
- reset  input  1  synchronous, active-high reset.
- BCD3  input  4  thousands digit from the counter.
- BCD2  input  4  hundreds digit.
- BCD1  input  4  tens digit.
- BCD0  input  4  units digit.
- dp_en  input  4  decimal-point enable, one bit per digit; bit k belongs to digit k.
- seg  output  7  segment cathodes, active-low, ordered {g,f,e,d,c,b,a}.
- dp  output  1  decimal-point cathode, active-low.
- an  output  4  digit anodes, active-low; an[0] is the rightmost digit (BCD0).

Behaviour:
- Single clock domain. Reset is synchronous and active-high; clock and reset are named clk and reset.
- Reset state:
  - prescaler = 0, digit index = 0.
  - Snapshot digits = 0, snapshot dp = 0.
  - an = 4'b1111, seg = 7'b1111111, dp = 1.
  - Reset asserted mid-scan takes effect on the next clk edge and overrides all else.
- Prescaler:
  - Counts 0..REFRESH_DIV-1 and wraps to 0.
  - tick = 1 in the cycle where prescaler == REFRESH_DIV-1.
- Digit index:
  - On tick, advances 0→1→2→3→0.
  - Otherwise holds.
- Snapshot:
  - On tick with index == 3 (frame end), latch BCD3..BCD0 and dp_en into snapshot registers.
  - Inputs are ignored at all other times.
  - The first snapshot after reset occurs at the 4th tick. Until then the snapshot is all zeros.
- Output register:
  - an, seg and dp are registered, computed from the current index and snapshot.
  - Outputs therefore follow an index change by exactly 1 clk. First valid display is the cycle after reset deasserts (digit 0, value 0).
- Anode: an = ~(1 << index) unless digit[index] is blanked, in which case an = 4'b1111.
- Blanking (BLANK_LZ = 1):
  - Digit k is blanked iff k > 0, every snapshot digit at positions ≥ k equals 0, and no snapshot dp bit at positions ≥ k is set.
  - Digit 0 is never blanked.
  - With BLANK_LZ = 0, nothing is blanked.
- Segment decode, active-low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - 10–15 = 0111111 (only g lit, shown as a dash).
- Decimal point: dp = ~snapshot_dp[index] when the digit is not blanked; otherwise dp = 1.
- Simultaneous events: when input digits change in the same cycle as the frame-end tick, the new values are captured (sampled at that edge).

Test Plan:
- Reset, REFRESH_DIV=4, inputs 0 → during reset an=1111, seg=1111111, dp=1. Cycle after release: an=1110, seg=1000000. Digits 1–3 are blanked, so an=1111 in their slots.
- Inputs 1,2,3,4 held; run 2 frames (32 clks) → after the first snapshot, each slot shows: an=1110 with seg=0011001 (4), an=1101 with 0110000 (3), an=1011 with 0100100 (2), an=0111 with 1111001 (1). Each slot lasts 4 clks and lags tick by 1 clk.
- Leading-zero blanking: inputs 0,0,0,7 then 0,0,5,0 → only digit 0 shows 1111000; then digit 1 shows 0010010 and digit 0 shows 1000000, with digits 2–3 blanked. With BLANK_LZ=0, all four anodes are active showing 0s.
- Tearing: change inputs from 1234 to 5678 mid-frame (index 1) → the rest of the frame still shows 1234. The next frame shows 5678 with no mix.
- Invalid and dp: BCD1=4'hC, dp_en=0100 with other digits 0 → digit 1 seg=0111111. Digit 2 is unblanked with seg=1000000 and dp=0 in its slot. dp=1 in all other slots.
- Mid-scan reset: assert reset at index 2 → next edge gives an=1111, index=0, snapshot=0. Scan restarts from digit 0.
